// File: rtl/psum_drain.sv
// Output deskew + FIFO for the 4x4 systolic array: realigns skewed bottom-edge sums,
// buffers whole vectors and tracks tile completion. Optional ReLU clamp: PSUM_DRAIN_RELU_EN.
module psum_drain #(
    parameter int ACC_WIDTH  = 32,
    parameter int COLS       = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [CNT_WIDTH-1:0]      tile_len,
    input  logic                      in_valid,
    input  logic [ACC_WIDTH*COLS-1:0] psum_in_flat,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_WIDTH*COLS-1:0] out_data_flat,
    output logic                      busy,
    output logic                      tile_done,
    output logic                      overflow
);

    localparam int VEC_W  = ACC_WIDTH * COLS;
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic [COLS-2:0]  vld_pipe;
    logic             strobe;
    logic [VEC_W-1:0] aligned_vec;

    // The aligned-vector strobe is lane 0's valid, delayed to match the longest data path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= in_valid;
            for (int i = 1; i < COLS - 1; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    assign strobe = vld_pipe[COLS-2];

    for (genvar c = 0; c < COLS; c++) begin : g_lane
        localparam int DEPTH = COLS - 1 - c;
        logic [ACC_WIDTH-1:0] lane_in;
        logic [ACC_WIDTH-1:0] lane_d;

        assign lane_in = psum_in_flat[c*ACC_WIDTH +: ACC_WIDTH];

        if (DEPTH == 0) begin : g_direct
            assign lane_d = lane_in;
        end else begin : g_delay
            logic [ACC_WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= lane_in;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign lane_d = stage[DEPTH-1];
        end

`ifdef PSUM_DRAIN_RELU_EN
        assign aligned_vec[c*ACC_WIDTH +: ACC_WIDTH] = lane_d[ACC_WIDTH-1] ? '0 : lane_d;
`else
        assign aligned_vec[c*ACC_WIDTH +: ACC_WIDTH] = lane_d;
`endif
    end

    logic [VEC_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             push_en;
    logic             drop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
    assign push_en    = strobe && (!fifo_full || pop);
    assign drop       = strobe && fifo_full && !pop;

    assign out_data_flat = mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_en) begin
                mem[wr_ptr[ADDR_W-1:0]] <= aligned_vec;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] tile_len_q, tile_len_d;
    logic [CNT_WIDTH-1:0] pop_cnt_q, pop_cnt_d;
    logic [CNT_WIDTH-1:0] pop_cnt_inc;
    logic                 zero_done_q, zero_done_d;
    logic                 run_done;
    logic                 tile_start;

    assign pop_cnt_inc = pop_cnt_q + CNT_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tile_len_q  <= '0;
            pop_cnt_q   <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tile_len_q  <= tile_len_d;
            pop_cnt_q   <= pop_cnt_d;
            zero_done_q <= zero_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tile_len_d  = tile_len_q;
        pop_cnt_d   = pop_cnt_q;
        zero_done_d = 1'b0;
        run_done    = 1'b0;
        tile_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (tile_len != '0) begin
                        state_d    = ST_RUN;
                        tile_len_d = tile_len;
                        pop_cnt_d  = '0;
                        tile_start = 1'b1;
                    end else begin
                        zero_done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (pop) begin
                    pop_cnt_d = pop_cnt_inc;
                    if (pop_cnt_inc == tile_len_q) begin
                        run_done = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q == ST_RUN);
    assign tile_done = run_done || zero_done_q;

    // A drop in the same cycle as a tile start is still reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (tile_start) begin
            overflow <= 1'b0;
        end
    end

endmodule
